sync_fifo: RTL and testbench

//   Parametrised single-clock FIFO for the directed-test DUT area; successor to the
//   1-bit wr/rd/empty/full FIFO. Generalised data width and depth; adds occupancy

---
 rtl/config_pkg.sv | 16 +
 rtl/sync_fifo_mem.sv | 23 ++
 rtl/sync_fifo.sv | 92 +++++++++
 tb/tb_sync_fifo.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/config_pkg.sv
// Shared constants, pointer/count types and elaboration helpers for sync_fifo.
package config_pkg;

  localparam int FIFO_DATA_W_DEF = 8;
  localparam int FIFO_DEPTH_DEF  = 16;
  localparam int FIFO_ADDR_W_DEF = $clog2(FIFO_DEPTH_DEF);

  // Extra MSB on pointers distinguishes full from empty after a wrap.
  typedef logic [FIFO_ADDR_W_DEF:0] fifo_ptr_t;
  typedef logic [FIFO_ADDR_W_DEF:0] fifo_cnt_t;

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x DATA_W storage for sync_fifo: one synchronous write port, one asynchronous read port.
module sync_fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Parametrised single-clock FIFO with occupancy count, almost flags and overflow/underflow pulses.
// Define FIFO_FWFT_EN for first-word-fall-through output; default build registers dout on reads.
module sync_fifo
  import config_pkg::*;
#(
  parameter int DATA_W    = FIFO_DATA_W_DEF,
  parameter int DEPTH     = FIFO_DEPTH_DEF,
  parameter int AF_THRESH = 12,
  parameter int AE_THRESH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr,
  input  logic [DATA_W-1:0]        din,
  input  logic                     rd,
  output logic [DATA_W-1:0]        dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] PTR_ONE  = 1;
  localparam logic [ADDR_W:0] WRAP_BIT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] AF_T     = AF_THRESH[ADDR_W:0];
  localparam logic [ADDR_W:0] AE_T     = AE_THRESH[ADDR_W:0];

  if (DEPTH < 2 || !is_pow2(DEPTH)) begin : g_bad_depth
    $error("sync_fifo: DEPTH (%0d) must be a power of two >= 2", DEPTH);
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("sync_fifo: AF_THRESH (%0d) must be in 1..DEPTH", AF_THRESH);
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $error("sync_fifo: AE_THRESH (%0d) must be in 0..DEPTH-1", AE_THRESH);
  end

  logic [ADDR_W:0]   wr_ptr, rd_ptr;
  logic              wr_acc, rd_acc;
  logic [DATA_W-1:0] mem_rdata;

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = ((wr_ptr ^ rd_ptr) == WRAP_BIT);
  assign wr_acc = wr && !full;
  assign rd_acc = rd && !empty;

  // Pointer difference is exact over 0..DEPTH thanks to the wrap bit.
  assign count        = wr_ptr - rd_ptr;
  assign almost_full  = (count >= AF_T);
  assign almost_empty = (count <= AE_T);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
      overflow  <= wr && full;
      underflow <= rd && empty;
    end
  end

  sync_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (din),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (mem_rdata)
  );

`ifdef FIFO_FWFT_EN
  assign dout = empty ? '0 : mem_rdata;
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         dout <= '0;
    else if (rd_acc) dout <= mem_rdata;
  end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo (DATA_W=8, DEPTH=16, AF=12, AE=2) against a queue model.
// Define FIFO_FWFT_EN for both RTL and bench to check the fall-through build.
module tb_sync_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr = 1'b0, rd = 1'b0;
  logic [7:0] din = '0;
  logic [7:0] dout;
  logic       empty, full, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;

  int tests = 0;
  int failed = 0;

  logic [7:0] q[$];
  logic [7:0] m_dout = '0;
  logic       m_ov = 1'b0, m_un = 1'b0;

  sync_fifo dut (
    .clk(clk), .rst(rst), .wr(wr), .din(din), .rd(rd), .dout(dout),
    .empty(empty), .full(full), .count(count),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_dout();
`ifdef FIFO_FWFT_EN
    return (q.size() > 0) ? q[0] : 8'h00;
`else
    return m_dout;
`endif
  endfunction

  // {count, empty, full, almost_full, almost_empty, overflow, underflow, dout}
  function automatic logic [18:0] exp_vec();
    int n = q.size();
    return {5'(n), n == 0, n == DEPTH, n >= 12, n <= 2, m_ov, m_un, exp_dout()};
  endfunction

  function automatic logic [18:0] obs_vec();
    return {count, empty, full, almost_full, almost_empty, overflow, underflow, dout};
  endfunction

  task automatic model_reset();
    q.delete();
    m_dout = '0;
    m_ov = 1'b0;
    m_un = 1'b0;
  endtask

  // One clock: drive at negedge, update model from pre-edge state, settle 1ns past the edge.
  task automatic cyc(input logic w, input logic r, input logic [7:0] d);
    int n;
    @(negedge clk);
    wr = w; rd = r; din = d;
    @(posedge clk);
    n = q.size();
    m_ov = w && (n == DEPTH);
    m_un = r && (n == 0);
    if (r && n > 0) m_dout = q.pop_front();
    if (w && n < DEPTH) q.push_back(d);
    #1;
    wr = 1'b0; rd = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    tests++;
    if (obs_vec() !== 19'b00000_1_0_0_1_0_0_00000000) begin
      failed++; $display("FAIL reset_state got %b exp %b", obs_vec(), 19'b00000_1_0_0_1_0_0_00000000);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 1'b0, 8'(i));
      tests++;
      if (count !== 5'(i + 1)) begin
        failed++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, count, i + 1);
      end
    end
    tests++;
    if (full !== 1'b1 || count !== 5'd16) begin
      failed++; $display("FAIL fill_full got full=%b count=%0d exp full=1 count=16", full, count);
    end
    cyc(1'b1, 1'b0, 8'hEE);
    tests++;
    if (overflow !== 1'b1 || count !== 5'd16) begin
      failed++; $display("FAIL overflow_pulse got ov=%b count=%0d exp ov=1 count=16", overflow, count);
    end
    cyc(1'b0, 1'b0, 8'h00);
    tests++;
    if (overflow !== 1'b0) begin
      failed++; $display("FAIL overflow_width got %b exp 0", overflow);
    end
  endtask

  task automatic test_drain_underflow();
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b1, 8'h00);
      tests++;
      if (obs_vec() !== exp_vec()) begin
        failed++; $display("FAIL drain[%0d] got %h exp %h", i, obs_vec(), exp_vec());
      end
`ifndef FIFO_FWFT_EN
      tests++;
      if (dout !== 8'(i)) begin
        failed++; $display("FAIL drain_order[%0d] got %h exp %h", i, dout, 8'(i));
      end
`endif
    end
    tests++;
    if (empty !== 1'b1) begin
      failed++; $display("FAIL drain_empty got %b exp 1", empty);
    end
    cyc(1'b0, 1'b1, 8'h00);
    tests++;
    if (obs_vec() !== exp_vec() || underflow !== 1'b1) begin
      failed++; $display("FAIL underflow_pulse got %h exp %h", obs_vec(), exp_vec());
    end
`ifndef FIFO_FWFT_EN
    tests++;
    if (dout !== 8'h0F) begin
      failed++; $display("FAIL underflow_hold got %h exp 0f", dout);
    end
`endif
    cyc(1'b0, 1'b0, 8'h00);
    tests++;
    if (underflow !== 1'b0) begin
      failed++; $display("FAIL underflow_width got %b exp 0", underflow);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 8'($urandom));
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'b1, 8'(8'h40 + i));
      tests++;
      if (obs_vec() !== exp_vec() || count !== 5'd8) begin
        failed++; $display("FAIL b2b[%0d] got %h exp %h", i, obs_vec(), exp_vec());
      end
    end
    while (q.size() > 0) cyc(1'b0, 1'b1, 8'h00);
  endtask

  task automatic test_thresholds();
    for (int i = 0; i < 13; i++) begin
      cyc(1'b1, 1'b0, 8'($urandom));
      tests++;
      if (almost_empty !== (i + 1 <= 2) || almost_full !== (i + 1 >= 12)) begin
        failed++; $display("FAIL thresh_fill[%0d] got ae=%b af=%b", i + 1, almost_empty, almost_full);
      end
    end
    cyc(1'b0, 1'b1, 8'h00);
    cyc(1'b0, 1'b1, 8'h00);
    tests++;
    if (count !== 5'd11 || almost_full !== 1'b0) begin
      failed++; $display("FAIL thresh_af_drop got count=%0d af=%b exp count=11 af=0", count, almost_full);
    end
    while (q.size() > 0) cyc(1'b0, 1'b1, 8'h00);
  endtask

  task automatic test_simul_full_empty();
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'($urandom));
    cyc(1'b1, 1'b1, 8'h77);
    tests++;
    if (obs_vec() !== exp_vec() || overflow !== 1'b1 || count !== 5'd15) begin
      failed++; $display("FAIL rw_full got %h exp %h", obs_vec(), exp_vec());
    end
    while (q.size() > 0) cyc(1'b0, 1'b1, 8'h00);
    cyc(1'b1, 1'b1, 8'h5A);
    tests++;
    if (obs_vec() !== exp_vec() || underflow !== 1'b1 || count !== 5'd1) begin
      failed++; $display("FAIL rw_empty got %h exp %h", obs_vec(), exp_vec());
    end
    cyc(1'b0, 1'b1, 8'h00);
`ifndef FIFO_FWFT_EN
    tests++;
    if (dout !== 8'h5A) begin
      failed++; $display("FAIL rw_empty_data got %h exp 5a", dout);
    end
`endif
    tests++;
    if (obs_vec() !== exp_vec()) begin
      failed++; $display("FAIL rw_empty_after got %h exp %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'(8'h10 + i));
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    model_reset();
    tests++;
    if (empty !== 1'b1 || count !== 5'd0 || dout !== 8'h00) begin
      failed++; $display("FAIL midreset got empty=%b count=%0d dout=%h exp 1/0/00", empty, count, dout);
    end
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b1, 1'b0, 8'hA5);
`ifdef FIFO_FWFT_EN
    tests++;
    if (dout !== 8'hA5) begin
      failed++; $display("FAIL fwft_show got %h exp a5", dout);
    end
`endif
    cyc(1'b0, 1'b1, 8'h00);
`ifndef FIFO_FWFT_EN
    tests++;
    if (dout !== 8'hA5) begin
      failed++; $display("FAIL midreset_readback got %h exp a5", dout);
    end
`endif
    tests++;
    if (obs_vec() !== exp_vec()) begin
      failed++; $display("FAIL midreset_after got %h exp %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 400; i++) begin
      // Bias phases toward filling then draining so both boundaries are visited.
      logic w = ((i / 50) % 2 == 0) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 3);
      logic r = $urandom_range(0, 1) == 1;
      cyc(w, r, 8'($urandom));
      tests++;
      if (obs_vec() !== exp_vec()) begin
        failed++;
        if (bad < 10) $display("FAIL random[%0d] got %h exp %h", i, obs_vec(), exp_vec());
        bad++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_overflow();
    test_drain_underflow();
    test_back_to_back();
    test_thresholds();
    test_simul_full_empty();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
